// File: rtl/sram_cim_pkg.sv
// Shared types and helpers for the bit-serial SRAM compute-in-memory macro.
package sram_cim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_OUT
   } state_e;

   // Encoded in priority order: comp > wrt > wrtbuf > read.
   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_COMP,
      CMD_WRT,
      CMD_WRTBUF,
      CMD_READ
   } cmd_e;

   function automatic cmd_e decode_cmd(input logic comp, input logic wrt,
                                       input logic wrtbuf, input logic read);
      if (comp)        return CMD_COMP;
      else if (wrt)    return CMD_WRT;
      else if (wrtbuf) return CMD_WRTBUF;
      else if (read)   return CMD_READ;
      else             return CMD_NONE;
   endfunction

   function automatic int acc_width(input int group, input int in_bits);
      return $clog2(group + 1) + in_bits;
   endfunction

endpackage

// File: rtl/cim_column_mac.sv
// One array column: popcount of activation-bit AND weight-bit over the row group,
// folded into a shift-accumulator. CIM_SIGNED_EN adds the MSB subtract path.
module cim_column_mac
   import sram_cim_pkg::*;
#(
   parameter int GROUP   = 16,
   parameter int IN_BITS = 8,
   parameter int ACC_W   = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
`ifdef CIM_SIGNED_EN
   input  logic             neg_i,
`endif
   input  logic [GROUP-1:0] bits_i,
   output logic [ACC_W-1:0] acc_o
);
   localparam int POP_W = $clog2(GROUP + 1);

   logic [POP_W-1:0] pop;
   logic [ACC_W-1:0] acc_q, acc_d, shifted;

   always_comb begin
      pop = '0;
      for (int r = 0; r < GROUP; r++) pop = pop + POP_W'(bits_i[r]);
   end

   assign shifted = acc_q << 1;

`ifdef CIM_SIGNED_EN
   // Two's complement activation: the MSB carries negative weight.
   assign acc_d = neg_i ? shifted - ACC_W'(pop) : shifted + ACC_W'(pop);
`else
   assign acc_d = shifted + ACC_W'(pop);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     acc_q <= '0;
      else if (clr_i) acc_q <= '0;
      else if (en_i)  acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/sram_cim_bitserial_macro.sv
// Bit-serial SRAM CIM macro: weight array, activation buffer, MAC sequencer and result stream.
// Optional CIM_SIGNED_EN honours signed_mode (two's complement activations).
//   state   | meaning
//   IDLE    | accept comp/wrt/wrtbuf/read
//   MAC     | one activation bit per cycle, MSB first
//   OUT     | stream one column accumulator per cycle
module sram_cim_bitserial_macro
   import sram_cim_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 9,
   parameter int IN_BITS = 8,
   parameter int GROUP   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] a,
   input  logic [DATA_W-1:0] d,
   input  logic              wrt,
   input  logic              wrtbuf,
   input  logic              read,
   input  logic              comp,
   input  logic              signed_mode,
   output logic [DATA_W-1:0] q,
   output logic              q_valid,
   output logic              busy,
   output logic              done
);
   localparam int ACC_W  = acc_width(GROUP, IN_BITS);
   localparam int GB     = $clog2(GROUP);
   localparam int BIT_W  = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
   localparam int COL_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(GROUP - 1);

   logic [DATA_W-1:0]  mem [2**ADDR_W];
   logic [IN_BITS-1:0] act [GROUP];

   state_e            state_q;
   logic [BIT_W-1:0]  bit_q;
   logic [COL_W-1:0]  col_q;
   logic [ADDR_W-1:0] base_q;
   logic [DATA_W-1:0] q_q;
   logic              q_valid_q, busy_q, done_q;
   logic              sgn_eff;
   cmd_e              cmd;

   logic [GROUP-1:0]  cbits [DATA_W];
   logic [ACC_W-1:0]  acc   [DATA_W];
   logic              clr, en;

   function automatic logic [DATA_W-1:0] extend(input logic [ACC_W-1:0] v, input logic sgn);
      if (sgn) return DATA_W'($signed(v));
      else     return DATA_W'(v);
   endfunction

   assign cmd = busy_q ? CMD_NONE : decode_cmd(comp, wrt, wrtbuf, read);
   assign clr = (cmd == CMD_COMP);
   assign en  = (state_q == ST_MAC);

`ifdef CIM_SIGNED_EN
   logic sgn_q, neg;
   assign sgn_eff = sgn_q;
   assign neg     = sgn_q && (bit_q == BIT_W'(IN_BITS - 1));
`else
   logic unused_signed_mode;
   assign unused_signed_mode = signed_mode;
   assign sgn_eff = 1'b0;
`endif

   // Storage is deliberately unreset; writes only land while idle.
   always_ff @(posedge clk) begin
      if (cmd == CMD_WRT)    mem[a] <= d;
      if (cmd == CMD_WRTBUF) act[a[GB-1:0]] <= d[IN_BITS-1:0];
   end

   always_comb begin
      for (int c = 0; c < DATA_W; c++)
         for (int r = 0; r < GROUP; r++)
            cbits[c][r] = act[r][bit_q] & mem[base_q | ADDR_W'(r)][c];
   end

   for (genvar c = 0; c < DATA_W; c++) begin : g_col
      cim_column_mac #(
         .GROUP   (GROUP),
         .IN_BITS (IN_BITS),
         .ACC_W   (ACC_W)
      ) u_col (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr_i  (clr),
         .en_i   (en),
`ifdef CIM_SIGNED_EN
         .neg_i  (neg),
`endif
         .bits_i (cbits[c]),
         .acc_o  (acc[c])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_q     <= '0;
         col_q     <= '0;
         base_q    <= '0;
         q_q       <= '0;
         q_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef CIM_SIGNED_EN
         sgn_q     <= 1'b0;
`endif
      end else begin
         q_valid_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd == CMD_COMP) begin
                  state_q <= ST_MAC;
                  busy_q  <= 1'b1;
                  bit_q   <= BIT_W'(IN_BITS - 1);
                  base_q  <= a & BASE_MASK;
`ifdef CIM_SIGNED_EN
                  sgn_q   <= signed_mode;
`endif
               end else if (cmd == CMD_READ) begin
                  q_q       <= mem[a];
                  q_valid_q <= 1'b1;
               end
            end
            ST_MAC: begin
               if (bit_q == '0) begin
                  state_q   <= ST_OUT;
                  col_q     <= '0;
                  q_valid_q <= 1'b1;
                  done_q    <= (DATA_W == 1);
               end else begin
                  bit_q <= bit_q - 1'b1;
               end
            end
            ST_OUT: begin
               if (col_q == COL_W'(DATA_W - 1)) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  q_q     <= extend(acc[col_q], sgn_eff);
               end else begin
                  col_q     <= col_q + 1'b1;
                  q_valid_q <= 1'b1;
                  done_q    <= (col_q == COL_W'(DATA_W - 2));
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // During OUT the accumulators are already final, so q is a mux of registers.
   always_comb begin
      q = q_q;
      if (state_q == ST_OUT) q = extend(acc[col_q], sgn_eff);
   end

   assign q_valid = q_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sram_cim_bitserial_macro.sv
// Scoreboard bench for sram_cim_bitserial_macro: directed vectors, queued expectations, negedge monitor.
module tb_sram_cim_bitserial_macro;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 9;
   localparam int IN_BITS = 8;
   localparam int GROUP   = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] a = '0;
   logic [DATA_W-1:0] d = '0;
   logic              wrt = 1'b0, wrtbuf = 1'b0, read = 1'b0, comp = 1'b0, signed_mode = 1'b0;
   logic [DATA_W-1:0] q;
   logic              q_valid, busy, done;

   typedef struct packed {
      logic [DATA_W-1:0] q;
      logic              done;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   sram_cim_bitserial_macro #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IN_BITS(IN_BITS), .GROUP(GROUP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .d(d), .wrt(wrt), .wrtbuf(wrtbuf),
      .read(read), .comp(comp), .signed_mode(signed_mode),
      .q(q), .q_valid(q_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && q_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_q_valid actual q=%0h done=%0b required none", q, done);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("q_stream{q,done}", {15'b0, q, done}, {15'b0, e.q, e.done});
         end
      end else if (rst_n && done) begin
         check("done_without_valid", {31'b0, done}, 32'd0);
      end
   end

   task automatic idle_inputs();
      comp = 1'b0; wrt = 1'b0; wrtbuf = 1'b0; read = 1'b0; signed_mode = 1'b0;
   endtask

   task automatic issue(input logic c, input logic w, input logic wb, input logic r, input logic sm,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      comp = c; wrt = w; wrtbuf = wb; read = r; signed_mode = sm; a = addr; d = data;
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic wr_row(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, addr, data);
   endtask

   task automatic wr_buf(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] val);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, idx, val);
   endtask

   task automatic rd_row(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] expv);
      exp_q.push_back({expv, 1'b0});
      issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, addr, '0);
   endtask

   // Launch a MAC; col0 and the other columns have hand-computed results.
   task automatic run_comp(input logic [ADDR_W-1:0] addr, input logic sm,
                           input logic [DATA_W-1:0] col0, input logic [DATA_W-1:0] rest,
                           input logic same_wrt, input logic poke, input string tag);
      int n;
      for (int c = 0; c < DATA_W; c++)
         exp_q.push_back({(c == 0) ? col0 : rest, (c == DATA_W - 1)});
      issue(1'b1, same_wrt, 1'b0, 1'b0, sm, addr, 16'hFFFF);
      n = 0;
      while (busy && n < 100) begin
         if (poke && n == 3) begin
            wrt = 1'b1; a = 9'd1; d = 16'hFFFF;
         end else begin
            wrt = 1'b0;
         end
         n++;
         @(posedge clk); #1;
      end
      wrt = 1'b0;
      check({tag, "_busy_cycles"}, n, IN_BITS + DATA_W);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [DATA_W-1:0] signed_exp;
`ifdef CIM_SIGNED_EN
      signed_exp = 16'hF800;
`else
      signed_exp = 16'h0800;
`endif
      #1;
      check("reset_q", q, 0);
      check("reset_q_valid", q_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      wr_row(9'd5, 16'hA5A5);
      rd_row(9'd5, 16'hA5A5);
      @(posedge clk); #1;
      check("read_hold_q", q, 16'hA5A5);
      check("read_pulse_q_valid", q_valid, 0);

      for (int r = 0; r < 16; r++) wr_row(ADDR_W'(r), 16'hFFFF);
      for (int i = 0; i < GROUP; i++) wr_buf(ADDR_W'(i), 16'h0001);
      run_comp(9'd0, 1'b0, 16'd16, 16'd16, 1'b0, 1'b0, "comp_ones");

      for (int r = 16; r < 32; r++) wr_row(ADDR_W'(r), 16'h0001);
      for (int i = 0; i < GROUP; i++) wr_buf(ADDR_W'(i), 16'h00FF);
      run_comp(9'd16, 1'b0, 16'd4080, 16'd0, 1'b0, 1'b0, "comp_255");

      for (int r = 0; r < 16; r++) wr_row(ADDR_W'(r), 16'h0001);
      for (int i = 0; i < GROUP; i++) wr_buf(ADDR_W'(i), 16'h0080);
      run_comp(9'd0, 1'b1, signed_exp, 16'd0, 1'b0, 1'b0, "comp_signed");

      run_comp(9'd0, 1'b0, 16'h0800, 16'd0, 1'b1, 1'b1, "comp_wrt_drop");
      rd_row(9'd0, 16'h0001);
      rd_row(9'd1, 16'h0001);

      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, '0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_q", q, 0);
      check("abort_q_valid", q_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      run_comp(9'd0, 1'b0, 16'h0800, 16'd0, 1'b0, 1'b0, "comp_after_abort");

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
